// File: rtl/anspwm_sched.sv
// PWM target scheduler: one-entry sample hold, frame-tick target loading,
// and a LAT-deep valid tag pipeline that mirrors the downstream stage chain.
module anspwm_sched #(
  parameter int LAT = 4,
  parameter int PW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [PW-1:0] period,
  input  logic          s_valid,
  input  logic [15:0]   s_data,
  output logic          s_ready,
  output logic [15:0]   tgt_out,
  output logic          tgt_load,
  output logic          res_valid,
  output logic          underrun,
  output logic [15:0]   frame_cnt,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [PW-1:0] PER_ONE  = PW'(1'b1);
  localparam logic [PW-1:0] PER_ZERO = {PW{1'b0}};

  state_t         state_q, state_d;
  logic [PW-1:0]  per_q, per_d;
  logic [PW-1:0]  timer_q, timer_d;
  logic [15:0]    hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic [15:0]    tgt_q, tgt_d;
  logic           load_q, load_d;
  logic           und_q, und_d;
  logic [15:0]    fcnt_q, fcnt_d;
  logic [LAT-1:0] vld_q, vld_d;
  logic [LAT:0]   vld_ext_s;
  logic           busy_q, busy_d;
  logic           ready_q, ready_d;
  logic           tick_s;
  logic           accept_s;

  assign tick_s    = (state_q == ST_RUN) && (timer_q == PER_ZERO);
  assign accept_s  = s_valid && ready_q;
  // The tag pipeline shifts in every state; vld_d is also the drain-empty test.
  assign vld_ext_s = {vld_q, load_q};
  assign vld_d     = vld_ext_s[LAT-1:0];

  // Next-state computation for the control FSM, hold register and frame bookkeeping.
  always_comb begin
    state_d     = state_q;
    per_d       = per_q;
    timer_d     = timer_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tgt_d       = tgt_q;
    load_d      = 1'b0;
    und_d       = 1'b0;
    fcnt_d      = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          per_d   = (period == PER_ZERO) ? PER_ONE : period;
          timer_d = PER_ZERO;
          fcnt_d  = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        timer_d = (timer_q == (per_q - PER_ONE)) ? PER_ZERO : (timer_q + PER_ONE);
        // A tick consumes the hold before this cycle's accept can refill it.
        if (tick_s) begin
          fcnt_d = fcnt_q + 16'd1;
          if (hold_full_q) begin
            tgt_d       = hold_q;
            load_d      = 1'b1;
            hold_full_d = 1'b0;
          end else begin
            und_d = 1'b1;
          end
        end else begin
          fcnt_d = fcnt_q;
        end
        if (accept_s) begin
          hold_d      = s_data;
          hold_full_d = 1'b1;
        end else begin
          hold_d = hold_q;
        end
        if (!enable) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (vld_d == {LAT{1'b0}}) begin
          state_d     = ST_IDLE;
          hold_full_d = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        hold_full_d = 1'b0;
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_RUN) && !hold_full_d;
  end

  // State and output registers with asynchronous abort on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      per_q       <= PER_ONE;
      timer_q     <= PER_ZERO;
      hold_q      <= 16'd0;
      hold_full_q <= 1'b0;
      tgt_q       <= 16'd0;
      load_q      <= 1'b0;
      und_q       <= 1'b0;
      fcnt_q      <= 16'd0;
      vld_q       <= {LAT{1'b0}};
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      timer_q     <= timer_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tgt_q       <= tgt_d;
      load_q      <= load_d;
      und_q       <= und_d;
      fcnt_q      <= fcnt_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  assign s_ready   = ready_q;
  assign tgt_out   = tgt_q;
  assign tgt_load  = load_q;
  assign res_valid = vld_q[LAT-1];
  assign underrun  = und_q;
  assign frame_cnt = fcnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_anspwm_sched.sv
// Randomized bench for anspwm_sched against an event-scheduling reference model,
// plus directed scenarios pinned with hand-computed values.
module tb_anspwm_sched;
  localparam int LAT = 4;
  localparam int PW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] period = '0;
  logic          s_valid = 1'b0;
  logic [15:0]   s_data = 16'd0;
  logic          s_ready, tgt_load, res_valid, underrun, busy;
  logic [15:0]   tgt_out, frame_cnt;

  anspwm_sched #(.LAT(LAT), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .tgt_out(tgt_out), .tgt_load(tgt_load), .res_valid(res_valid),
    .underrun(underrun), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;
  localparam int SEL_TGT = 0, SEL_LOAD = 1, SEL_RES = 2, SEL_UND = 3,
                 SEL_FCNT = 4, SEL_BUSY = 5, SEL_READY = 6;

  // Reference model: mode, sample slot, and absolute cycle stamps for result pulses.
  int          m_mode = M_IDLE;
  int          m_per = 1;
  int          m_run_cyc = 0;
  int          m_cyc = 0;
  bit          m_full = 1'b0;
  logic [15:0] m_hold = 16'd0;
  logic [15:0] e_tgt = 16'd0;
  logic [15:0] e_fcnt = 16'd0;
  bit          e_load = 1'b0, e_und = 1'b0, e_res = 1'b0;
  int          res_times[$];
  bit          m_tick, m_acc;

  typedef struct { string nm; int sel; int want; } lit_t;
  lit_t lit_q[$];
  int   lit_rd = 0;

  int n_checks = 0;
  int n_fail   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_per = 1; m_run_cyc = 0; m_full = 1'b0; m_hold = 16'd0;
      e_tgt = 16'd0; e_fcnt = 16'd0; e_load = 1'b0; e_und = 1'b0; e_res = 1'b0;
      res_times.delete();
    end else begin
      m_tick = (m_mode == M_RUN) && ((m_run_cyc % m_per) == 0);
      m_acc  = s_valid && (m_mode == M_RUN) && !m_full;
      e_load = 1'b0;
      e_und  = 1'b0;
      if (m_tick) begin
        e_fcnt = e_fcnt + 16'd1;
        if (m_full) begin
          e_tgt  = m_hold;
          e_load = 1'b1;
          m_full = 1'b0;
          res_times.push_back(m_cyc + 1 + LAT);
        end else begin
          e_und = 1'b1;
        end
      end
      if (m_acc) begin
        m_hold = s_data;
        m_full = 1'b1;
      end
      if (m_mode == M_IDLE) begin
        if (enable) begin
          m_mode = M_RUN; m_per = (period == 0) ? 1 : int'(period);
          m_run_cyc = 0; e_fcnt = 16'd0;
        end
      end else if (m_mode == M_RUN) begin
        m_run_cyc++;
        if (!enable) m_mode = M_DRAIN;
      end else begin
        if (res_times.size() == 0) begin
          m_mode = M_IDLE;
          m_full = 1'b0;
        end
      end
      m_cyc++;
      e_res = 1'b0;
      if (res_times.size() > 0 && res_times[0] == m_cyc) begin
        e_res = 1'b1;
        void'(res_times.pop_front());
      end
    end
  end

  function automatic int pick(input int sel);
    case (sel)
      SEL_TGT:   return int'(tgt_out);
      SEL_LOAD:  return int'(tgt_load);
      SEL_RES:   return int'(res_valid);
      SEL_UND:   return int'(underrun);
      SEL_FCNT:  return int'(frame_cnt);
      SEL_BUSY:  return int'(busy);
      SEL_READY: return int'(s_ready);
      default:   return -1;
    endcase
  endfunction

  task automatic cmp(input string nm, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Single compare process: model check every cycle, then any pinned literals.
  always @(negedge clk) begin
    cmp("tgt_out",   int'(tgt_out),   int'(e_tgt));
    cmp("tgt_load",  int'(tgt_load),  int'(e_load));
    cmp("res_valid", int'(res_valid), int'(e_res));
    cmp("underrun",  int'(underrun),  int'(e_und));
    cmp("frame_cnt", int'(frame_cnt), int'(e_fcnt));
    cmp("busy",      int'(busy),      int'(m_mode != M_IDLE));
    cmp("s_ready",   int'(s_ready),   int'((m_mode == M_RUN) && !m_full));
    cmp("load_und_excl", int'(tgt_load && underrun), 0);
    while (lit_rd < lit_q.size()) begin
      cmp(lit_q[lit_rd].nm, pick(lit_q[lit_rd].sel), lit_q[lit_rd].want);
      lit_rd++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input int sel, input int want);
    lit_t l;
    l.nm = nm; l.sel = sel; l.want = want;
    lit_q.push_back(l);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // period=3, no samples: underrun every 3 clocks from the first RUN cycle
    period = 8'd3; enable = 1'b1;
    step(); lit("A_busy", SEL_BUSY, 1); lit("A_ready", SEL_READY, 1);
            lit("A_und0", SEL_UND, 0);  lit("A_fcnt0", SEL_FCNT, 0);
    step(); lit("A_und1", SEL_UND, 1);  lit("A_fcnt1", SEL_FCNT, 1);
    step(); lit("A_und_gap", SEL_UND, 0);
    step();
    step(); lit("A_und2", SEL_UND, 1);  lit("A_fcnt2", SEL_FCNT, 2);
    repeat (3) step();
    lit("A_fcnt3", SEL_FCNT, 3); lit("A_tgt0", SEL_TGT, 0);
    enable = 1'b0;
    repeat (4) step();

    // period=0 acts as 1: underrun and load alternate at the hold refill rate
    period = 8'd0; s_valid = 1'b1; s_data = 16'hA5A5; enable = 1'b1;
    step(); lit("B_ready", SEL_READY, 1);
    step(); lit("B_und1", SEL_UND, 1);
    step(); lit("B_load1", SEL_LOAD, 1); lit("B_tgt", SEL_TGT, 16'hA5A5);
    step(); lit("B_und2", SEL_UND, 1);
    step(); lit("B_load2", SEL_LOAD, 1);
    s_valid = 1'b0;
    step(); enable = 1'b0;
    step();
    step(); lit("B_drain_busy", SEL_BUSY, 1);
    step(); lit("B_res", SEL_RES, 1); lit("B_res_busy", SEL_BUSY, 1);
    step(); lit("B_idle", SEL_BUSY, 0);
    repeat (3) step();

    // Reset during DRAIN with a tag in flight
    period = 8'd5; s_data = 16'h1234; s_valid = 1'b1; enable = 1'b1;
    repeat (7) step();
    lit("C_load", SEL_LOAD, 1); lit("C_tgt", SEL_TGT, 16'h1234);
    enable = 1'b0; s_valid = 1'b0;
    step(); lit("C_drain", SEL_BUSY, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    lit("C_rst_busy", SEL_BUSY, 0); lit("C_rst_tgt", SEL_TGT, 0);
    lit("C_rst_res", SEL_RES, 0);   lit("C_rst_ready", SEL_READY, 0);
    step(); rst_n = 1'b1;
    repeat (8) step();

    // frame_cnt wrap after 65536 ticks at period=1
    period = 8'd1; enable = 1'b1;
    step();
    repeat (65535) step();
    lit("D_fcnt_max", SEL_FCNT, 16'hFFFF);
    step();
    lit("D_fcnt_wrap", SEL_FCNT, 0); lit("D_und", SEL_UND, 1);
    enable = 1'b0;
    repeat (4) step();

    // Randomized traffic with occasional asynchronous reset pulses
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      if ($urandom_range(0, 3) == 0) period = 8'($urandom_range(0, 6));
      s_valid = ($urandom_range(0, 2) != 0);
      s_data  = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 599) == 0) begin
        #2;
        rst_n = 1'b0;
      end
    end
    step();
    rst_n = 1'b1; enable = 1'b0; s_valid = 1'b0;
    repeat (30) step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
